jitter_buffer: RTL and testbench
================================

# jitter_buffer

Receive-side playback buffer between `decipher` and the speaker PDM path. It absorbs arrival jitter of deciphered 16-byte audio blocks from the RF link. Whole blocks are queued in a small block FIFO, and playback is held off until a prefill threshold is reached. Afterwards it emits one signed 8-bit sample per 12 kHz request, outputs silence on underrun, and drops whole blocks on overflow.

## Interface
- `DEPTH_BLOCKS`, 4: block slots in the FIFO; power of two, ≥2
- `PREFILL`, 2: blocks that must be stored before leaving FILL; 1..DEPTH_BLOCKS
- `BLOCK_BYTES`, 16: samples per block; power of two
- `SAMPLE_WIDTH`, 8: signed sample width
- `clk_in`  in  1  system clock (98.3 MHz audio clock domain)
- `rst_in`  in  1  reset; one clock, synchronous, active-high
- `block_valid_in`  in  1  single-cycle strobe: `block_in` holds a new deciphered block
- `block_in`  in  [BLOCK_BYTES-1:0][SAMPLE_WIDTH-1:0]  block; byte 0 is the oldest sample
- `request_in`  in  1  single-cycle 12 kHz sample request
- `sample_out`  out  signed SAMPLE_WIDTH  current sample, held between requests
- `sample_valid_out`  out  1  single-cycle strobe one cycle after each `request_in`
- `playing_out`  out  1  high in PLAY state
- `level_out`  out  $clog2(DEPTH_BLOCKS)+1  blocks stored, including a partially played head
- `overflow_out`  out  1  single-cycle pulse: incoming block dropped
- `underrun_out`  out  1  single-cycle pulse: request arrived with the FIFO empty while in PLAY

## Operation
- Storage: DEPTH_BLOCKS × BLOCK_BYTES × SAMPLE_WIDTH register array.
  - Write pointer `wr_ptr`, read pointer `rd_ptr` and byte index `rd_byte`.
  - Both pointers wrap modulo DEPTH_BLOCKS.
- Write path:
  - `block_valid_in` with level < DEPTH_BLOCKS: store the block at `wr_ptr`, then increment `wr_ptr` and level.
  - `block_valid_in` at level == DEPTH_BLOCKS: drop the block and pulse `overflow_out`. Stored data is untouched.
  - Exception: if a pop happens in the same cycle, the write is accepted and level stays the same.
- States: FILL (reset state) and PLAY.
- FILL:
  - Each request outputs `sample_out`=0 with `sample_valid_out` pulsed; stored data is not consumed.
  - Go to PLAY when level ≥ PREFILL. Evaluation uses the registered level, so a block written this cycle counts from the next cycle.
- PLAY:
  - Each request with level > 0 outputs block[`rd_ptr`][`rd_byte`], then increments `rd_byte`.
  - When `rd_byte` wraps from BLOCK_BYTES-1 to 0: increment `rd_ptr` and decrement level (pop).
- Underrun:
  - A PLAY request with level == 0 outputs 0, pulses `underrun_out` and `sample_valid_out`, and returns to FILL.
  - `rd_byte` is already 0 at this point, so no realignment is needed.
- Simultaneous write and underrun request at level 0: the write is stored, the underrun still fires, and the state goes to FILL.
- Sample arithmetic: samples pass through unchanged as two's complement; no scaling or saturation.

## Timing
- Request to `sample_out` / `sample_valid_out`: 1 cycle latency, registered. The same registered edge updates `rd_byte`, pointers, level, state and pulses.
- Write to level update: 1 cycle.
- Earliest audible sample after an empty start: the first request issued at least 1 cycle after the PREFILL-th block strobe.
- Reset (at any time, including mid-block) sets:
  - pointers, `rd_byte` and level = 0; state FILL
  - `sample_out`=0 and all pulse outputs 0
  - `playing_out`=0 and `level_out`=0
  - Stored array contents need not be cleared.
- Inputs are always accepted (no backpressure). Requests arrive at least 8000 cycles apart; blocks arrive at least 1 cycle apart.

## Structure
- Shared package `wtf_audio_pkg`:
  - `BLOCK_BYTES` and `SAMPLE_WIDTH` constants
  - typedef `audio_block_t` (packed [BLOCK_BYTES-1:0][SAMPLE_WIDTH-1:0] signed), also used by `create_block`, `cipher` and `decipher`
  - state enum `jb_state_t` {FILL, PLAY}
- One sub-module, `block_fifo`: pointers, level, write/pop arbitration, full/empty. Exposes the head block and a pop strobe.
- `jitter_buffer` holds the FSM, byte sequencing and output registers.

## Test plan
- Prefill: reset, write blocks A (bytes 0..15 = 1..16) and B, then issue 3 requests. Required: outputs 1, 2, 3; `playing_out`=1; level=2. Requests issued before B was written return 0.
- Drain and pop: continue requests to the 16th. Required: outputs through 16, then 17th request outputs B[0]; level drops to 1 on the 16th request edge.
- Underrun: drain all blocks, then one more request. Required: output 0, `underrun_out` 1 pulse, `playing_out`=0; the next 2 writes restart playback at byte 0.
- Overflow: write 5 blocks in FILL with DEPTH_BLOCKS=4. Required: 5th dropped, `overflow_out` 1 pulse, level=4; playback order is blocks 1–4.
- Simultaneous: full FIFO, 16th-byte request in the same cycle as a block write. Required: write accepted, no overflow, level stays 4.
- Reset mid-block: after 7 samples played, assert `rst_in` for 1 cycle. Required: level=0, FILL, `sample_out`=0; the next request returns 0.

Source files
------------

// File: rtl/wtf_audio_pkg.sv
// Shared audio types for the RF audio path: block geometry, block type and playback states.
package wtf_audio_pkg;
   localparam int BLOCK_BYTES  = 16;
   localparam int SAMPLE_WIDTH = 8;

   typedef logic signed [BLOCK_BYTES-1:0][SAMPLE_WIDTH-1:0] audio_block_t;

   typedef enum logic {FILL = 1'b0, PLAY = 1'b1} jb_state_t;
endpackage

// File: rtl/block_fifo.sv
// Whole-block FIFO for the jitter buffer: pointers, occupancy and write/pop arbitration.
module block_fifo #(
   parameter int DEPTH_BLOCKS = 4,
   parameter int BLOCK_BYTES  = 16,
   parameter int SAMPLE_WIDTH = 8
) (
   input  logic                                    clk_in,
   input  logic                                    rst_in,
   input  logic                                    wr_in,
   input  logic [BLOCK_BYTES-1:0][SAMPLE_WIDTH-1:0] wr_block_in,
   input  logic                                    pop_in,
   output logic [BLOCK_BYTES-1:0][SAMPLE_WIDTH-1:0] head_block_out,
   output logic [$clog2(DEPTH_BLOCKS):0]           level_out,
   output logic                                    empty_out,
   output logic                                    drop_out
);
   localparam int PW = $clog2(DEPTH_BLOCKS);
   localparam int LW = PW + 1;

   logic [BLOCK_BYTES-1:0][SAMPLE_WIDTH-1:0] mem_q [DEPTH_BLOCKS];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          full;
   logic          accept;

   // A pop in the same cycle frees the head slot, so a write at full is still accepted.
   always_comb begin
      full     = (level_q == LW'(DEPTH_BLOCKS));
      accept   = wr_in && (!full || pop_in);
      drop_out = wr_in && !accept;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_in) rd_ptr_d = rd_ptr_q + PW'(1);
      if (accept && !pop_in)      level_d = level_q + LW'(1);
      else if (!accept && pop_in) level_d = level_q - LW'(1);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (accept) mem_q[wr_ptr_q] <= wr_block_in;
   end

   assign head_block_out = mem_q[rd_ptr_q];
   assign level_out      = level_q;
   assign empty_out      = (level_q == '0);
endmodule

// File: rtl/jitter_buffer.sv
// Receive-side playback buffer: prefill/play FSM, per-request byte sequencing over the
// head block, silence on underrun and whole-block drop on overflow.
module jitter_buffer #(
   parameter int DEPTH_BLOCKS = 4,
   parameter int PREFILL      = 2,
   parameter int BLOCK_BYTES  = wtf_audio_pkg::BLOCK_BYTES,
   parameter int SAMPLE_WIDTH = wtf_audio_pkg::SAMPLE_WIDTH
) (
   input  logic                                    clk_in,
   input  logic                                    rst_in,
   input  logic                                    block_valid_in,
   input  logic [BLOCK_BYTES-1:0][SAMPLE_WIDTH-1:0] block_in,
   input  logic                                    request_in,
   output logic signed [SAMPLE_WIDTH-1:0]          sample_out,
   output logic                                    sample_valid_out,
   output logic                                    playing_out,
   output logic [$clog2(DEPTH_BLOCKS):0]           level_out,
   output logic                                    overflow_out,
   output logic                                    underrun_out
);
   import wtf_audio_pkg::*;

   localparam int LW = $clog2(DEPTH_BLOCKS) + 1;
   localparam int BW = $clog2(BLOCK_BYTES);

   logic [BLOCK_BYTES-1:0][SAMPLE_WIDTH-1:0] head_block;
   logic [LW-1:0] level;
   logic          empty;
   logic          drop;
   logic          pop;
   logic          play;

   jb_state_t                 state_q, state_d;
   logic [BW-1:0]             rd_byte_q, rd_byte_d;
   logic signed [SAMPLE_WIDTH-1:0] sample_q, sample_d;
   logic                      valid_q, valid_d;
   logic                      over_q, over_d;
   logic                      under_q, under_d;

   block_fifo #(
      .DEPTH_BLOCKS(DEPTH_BLOCKS),
      .BLOCK_BYTES (BLOCK_BYTES),
      .SAMPLE_WIDTH(SAMPLE_WIDTH)
   ) u_fifo (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .wr_in         (block_valid_in),
      .wr_block_in   (block_in),
      .pop_in        (pop),
      .head_block_out(head_block),
      .level_out     (level),
      .empty_out     (empty),
      .drop_out      (drop)
   );

   // A FILL cycle whose registered level already meets PREFILL serves requests as PLAY.
   always_comb begin
      state_d   = state_q;
      rd_byte_d = rd_byte_q;
      sample_d  = sample_q;
      valid_d   = 1'b0;
      under_d   = 1'b0;
      over_d    = drop;
      pop       = 1'b0;
      play      = (state_q == PLAY) || (level >= LW'(PREFILL));
      if (state_q == FILL && level >= LW'(PREFILL)) state_d = PLAY;
      if (request_in) begin
         valid_d  = 1'b1;
         sample_d = '0;
         if (play) begin
            if (empty) begin
               under_d = 1'b1;
               state_d = FILL;
            end else begin
               sample_d  = $signed(head_block[rd_byte_q]);
               rd_byte_d = rd_byte_q + BW'(1);
               pop       = (rd_byte_q == BW'(BLOCK_BYTES - 1));
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= FILL;
         rd_byte_q <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         over_q    <= 1'b0;
         under_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_byte_q <= rd_byte_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         over_q    <= over_d;
         under_q   <= under_d;
      end
   end

   assign sample_out       = sample_q;
   assign sample_valid_out = valid_q;
   assign playing_out      = (state_q == PLAY);
   assign level_out        = level;
   assign overflow_out     = over_q;
   assign underrun_out     = under_q;
endmodule

// File: tb/tb_jitter_buffer.sv
// Directed bench for jitter_buffer: prefill, drain/pop, underrun, overflow, simultaneous
// write+pop at full, and reset in the middle of a block.
module tb_jitter_buffer;
   logic              clk_in = 1'b0;
   logic              rst_in = 1'b0;
   logic              block_valid_in = 1'b0;
   logic [15:0][7:0]  block_in = '0;
   logic              request_in = 1'b0;
   logic signed [7:0] sample_out;
   logic              sample_valid_out;
   logic              playing_out;
   logic [2:0]        level_out;
   logic              overflow_out;
   logic              underrun_out;

   int tests = 0;
   int fails = 0;

   jitter_buffer #(.DEPTH_BLOCKS(4), .PREFILL(2), .BLOCK_BYTES(16), .SAMPLE_WIDTH(8)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .block_valid_in  (block_valid_in),
      .block_in        (block_in),
      .request_in      (request_in),
      .sample_out      (sample_out),
      .sample_valid_out(sample_valid_out),
      .playing_out     (playing_out),
      .level_out       (level_out),
      .overflow_out    (overflow_out),
      .underrun_out    (underrun_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [15:0][7:0] mk_block(input logic [7:0] base);
      logic [15:0][7:0] b;
      for (int i = 0; i < 16; i++) b[i] = base + 8'(i);
      return b;
   endfunction

   task automatic do_reset();
      @(negedge clk_in) rst_in = 1'b1;
      @(negedge clk_in) rst_in = 1'b0;
   endtask

   task automatic write_block(input logic [7:0] base);
      @(negedge clk_in);
      block_in       = mk_block(base);
      block_valid_in = 1'b1;
      @(negedge clk_in);
      block_valid_in = 1'b0;
   endtask

   // Returns the registered response sampled on the negedge after the request edge.
   task automatic request(output logic [7:0] samp, output logic vld, output logic und);
      @(negedge clk_in) request_in = 1'b1;
      @(negedge clk_in) request_in = 1'b0;
      samp = sample_out;
      vld  = sample_valid_out;
      und  = underrun_out;
      repeat (2) @(negedge clk_in);
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({level_out, playing_out, sample_out, sample_valid_out, overflow_out, underrun_out} !== 15'd0) begin
         fails++;
         $display("FAIL reset_state: level=%0d play=%0b samp=%0d vld=%0b ovf=%0b und=%0b, required all 0",
                  level_out, playing_out, sample_out, sample_valid_out, overflow_out, underrun_out);
      end
   endtask

   task automatic test_prefill();
      logic [7:0] s; logic v, u;
      do_reset();
      write_block(8'd1);
      request(s, v, u);
      tests++;
      if (s !== 8'd0 || v !== 1'b1) begin
         fails++; $display("FAIL prefill_early_req: samp=%0d vld=%0b, required 0 and 1", s, v);
      end
      write_block(8'd17);
      repeat (2) @(negedge clk_in);
      for (int i = 1; i <= 3; i++) begin
         request(s, v, u);
         tests++;
         if (s !== 8'(i) || v !== 1'b1) begin
            fails++; $display("FAIL prefill_sample%0d: samp=%0d vld=%0b, required %0d and 1", i, s, v, i);
         end
      end
      tests++;
      if (playing_out !== 1'b1 || level_out !== 3'd2) begin
         fails++; $display("FAIL prefill_state: play=%0b level=%0d, required 1 and 2", playing_out, level_out);
      end
   endtask

   task automatic test_drain_pop();
      logic [7:0] s; logic v, u;
      for (int i = 4; i <= 16; i++) begin
         request(s, v, u);
         tests++;
         if (s !== 8'(i)) begin
            fails++; $display("FAIL drain_sample%0d: samp=%0d, required %0d", i, s, i);
         end
         if (i == 15) begin
            tests++;
            if (level_out !== 3'd2) begin
               fails++; $display("FAIL drain_level_before_pop: level=%0d, required 2", level_out);
            end
         end
      end
      tests++;
      if (level_out !== 3'd1) begin
         fails++; $display("FAIL drain_level_after_pop: level=%0d, required 1", level_out);
      end
      request(s, v, u);
      tests++;
      if (s !== 8'd17) begin
         fails++; $display("FAIL drain_next_block: samp=%0d, required 17", s);
      end
   endtask

   task automatic test_underrun();
      logic [7:0] s; logic v, u;
      for (int i = 18; i <= 32; i++) begin
         request(s, v, u);
         tests++;
         if (s !== 8'(i)) begin
            fails++; $display("FAIL underrun_drain%0d: samp=%0d, required %0d", i, s, i);
         end
      end
      tests++;
      if (level_out !== 3'd0 || playing_out !== 1'b1) begin
         fails++; $display("FAIL underrun_pre: level=%0d play=%0b, required 0 and 1", level_out, playing_out);
      end
      @(negedge clk_in) request_in = 1'b1;
      @(negedge clk_in) request_in = 1'b0;
      tests++;
      if (sample_out !== 8'sd0 || underrun_out !== 1'b1 || sample_valid_out !== 1'b1 || playing_out !== 1'b0) begin
         fails++; $display("FAIL underrun_event: samp=%0d und=%0b vld=%0b play=%0b, required 0,1,1,0",
                           sample_out, underrun_out, sample_valid_out, playing_out);
      end
      @(negedge clk_in);
      tests++;
      if (underrun_out !== 1'b0 || sample_valid_out !== 1'b0) begin
         fails++; $display("FAIL underrun_pulse_width: und=%0b vld=%0b, required 0 and 0", underrun_out, sample_valid_out);
      end
      write_block(8'd100);
      request(s, v, u);
      tests++;
      if (s !== 8'd0 || playing_out !== 1'b0) begin
         fails++; $display("FAIL underrun_refill_one: samp=%0d play=%0b, required 0 and 0", s, playing_out);
      end
      write_block(8'd120);
      repeat (2) @(negedge clk_in);
      request(s, v, u);
      tests++;
      if (s !== 8'd100 || playing_out !== 1'b1) begin
         fails++; $display("FAIL underrun_restart: samp=%0d play=%0b, required 100 and 1", s, playing_out);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] s; logic v, u;
      logic [7:0] bases [5];
      int bad;
      bases = '{8'h10, 8'h30, 8'h50, 8'hF0, 8'hA0};
      do_reset();
      for (int b = 0; b < 4; b++) write_block(bases[b]);
      tests++;
      if (overflow_out !== 1'b0 || level_out !== 3'd4) begin
         fails++; $display("FAIL overflow_fill: ovf=%0b level=%0d, required 0 and 4", overflow_out, level_out);
      end
      write_block(bases[4]);
      tests++;
      if (overflow_out !== 1'b1 || level_out !== 3'd4) begin
         fails++; $display("FAIL overflow_drop: ovf=%0b level=%0d, required 1 and 4", overflow_out, level_out);
      end
      @(negedge clk_in);
      tests++;
      if (overflow_out !== 1'b0) begin
         fails++; $display("FAIL overflow_pulse_width: ovf=%0b, required 0", overflow_out);
      end
      for (int b = 0; b < 4; b++) begin
         bad = 0;
         for (int i = 0; i < 16; i++) begin
            request(s, v, u);
            if (s !== bases[b] + 8'(i)) begin
               if (bad == 0) $display("FAIL overflow_order blk%0d byte%0d: samp=%0h, required %0h", b, i, s, bases[b] + 8'(i));
               bad++;
            end
         end
         tests++;
         if (bad != 0) fails++;
      end
      tests++;
      if (level_out !== 3'd0) begin
         fails++; $display("FAIL overflow_drained: level=%0d, required 0", level_out);
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] s; logic v, u;
      int bad;
      do_reset();
      for (int b = 0; b < 4; b++) write_block(8'(1 + 16 * b));
      repeat (2) @(negedge clk_in);
      for (int i = 1; i <= 15; i++) request(s, v, u);
      @(negedge clk_in);
      block_in       = mk_block(8'd65);
      block_valid_in = 1'b1;
      request_in     = 1'b1;
      @(negedge clk_in);
      block_valid_in = 1'b0;
      request_in     = 1'b0;
      tests++;
      if (sample_out !== 8'sd16 || overflow_out !== 1'b0 || level_out !== 3'd4) begin
         fails++; $display("FAIL simul_write_pop: samp=%0d ovf=%0b level=%0d, required 16,0,4",
                           sample_out, overflow_out, level_out);
      end
      bad = 0;
      for (int i = 17; i <= 65; i++) begin
         request(s, v, u);
         if (s !== 8'(i)) begin
            if (bad == 0) $display("FAIL simul_order%0d: samp=%0d, required %0d", i, s, i);
            bad++;
         end
      end
      tests++;
      if (bad != 0) fails++;
   endtask

   task automatic test_reset_midblock();
      logic [7:0] s; logic v, u;
      do_reset();
      write_block(8'd1);
      write_block(8'd17);
      repeat (2) @(negedge clk_in);
      for (int i = 1; i <= 7; i++) request(s, v, u);
      tests++;
      if (s !== 8'd7) begin
         fails++; $display("FAIL midblock_pre: samp=%0d, required 7", s);
      end
      do_reset();
      tests++;
      if (level_out !== 3'd0 || playing_out !== 1'b0 || sample_out !== 8'sd0) begin
         fails++; $display("FAIL midblock_reset: level=%0d play=%0b samp=%0d, required 0,0,0",
                           level_out, playing_out, sample_out);
      end
      request(s, v, u);
      tests++;
      if (s !== 8'd0 || v !== 1'b1 || playing_out !== 1'b0) begin
         fails++; $display("FAIL midblock_next_req: samp=%0d vld=%0b play=%0b, required 0,1,0", s, v, playing_out);
      end
   endtask

   initial begin
      test_reset();
      test_prefill();
      test_drain_pop();
      test_underrun();
      test_overflow();
      test_simultaneous();
      test_reset_midblock();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
